// File: rtl/uart_write_arbiter_if.sv
// Thread-side write handshake for uart_write_arbiter: lock request/grant,
// flow control and per-thread byte strobes.
interface uart_write_arbiter_if #(
  parameter int NTHREADS = 2
);
  logic [NTHREADS-1:0]   write_lock_req;
  logic [NTHREADS-1:0]   write_lock_res;
  logic [NTHREADS-1:0]   write_ready;
  logic [8*NTHREADS-1:0] write_data;
  logic [NTHREADS-1:0]   write_data_valid;

  modport master (
    output write_lock_req, write_data, write_data_valid,
    input  write_lock_res, write_ready
  );

  modport slave (
    input  write_lock_req, write_data, write_data_valid,
    output write_lock_res, write_ready
  );
endinterface

// File: rtl/uart_write_arbiter.sv
// Round-robin lock arbiter letting several threads share one 8N1 UART
// transmitter through a byte FIFO; a lock holder's bytes stay contiguous.
module uart_write_arbiter #(
  parameter int NTHREADS     = 2,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                clock,
  input  logic                reset,
  uart_write_arbiter_if.slave bus,
  output logic                uart_tx,
  output logic                overflow,
  output logic                idle
);
  localparam int OW   = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNTW-1:0] READY_LIMIT = CNTW'(FIFO_DEPTH - 2);
  localparam logic [CNTW-1:0] FULL_COUNT  = CNTW'(FIFO_DEPTH);
  localparam logic [CW-1:0]   BIT_LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [OW-1:0]   OWNER_LAST  = OW'(NTHREADS - 1);

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_RELEASE} arb_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  function automatic logic [NTHREADS-1:0] onehot(input logic [OW-1:0] idx);
    onehot = NTHREADS'(1) << idx;
  endfunction

  arb_state_t          arb_state_r;
  logic [OW-1:0]       owner_r;
  logic [OW-1:0]       rr_ptr_r;
  logic [NTHREADS-1:0] lock_res_r;

  logic          pick_found_s;
  logic [OW-1:0] pick_idx_s;
  logic          owner_req_s;
  logic          owner_valid_s;
  logic [7:0]    owner_data_s;
  logic          grant_active_s;

  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CNTW-1:0] count_r;
  logic            fifo_empty_s;
  logic            fifo_full_s;
  logic            push_req_s;
  logic            push_s;
  logic            drop_s;
  logic            pop_s;
  logic [7:0]      fifo_head_s;

  tx_state_t  tx_state_r;
  logic [CW-1:0] baud_cnt_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          baud_end_s;

  assign grant_active_s = (arb_state_r == ARB_GRANT);

  // Round-robin search for the first requester at or after rr_ptr_r.
  always_comb begin
    logic [OW:0]   cand_sum;
    logic [OW-1:0] cand_idx;
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    for (int k = 0; k < NTHREADS; k++) begin
      cand_sum = {1'b0, rr_ptr_r} + (OW+1)'(k);
      if (cand_sum >= (OW+1)'(NTHREADS)) begin
        cand_sum = cand_sum - (OW+1)'(NTHREADS);
      end else begin
        cand_sum = cand_sum;
      end
      cand_idx = cand_sum[OW-1:0];
      if (!pick_found_s && bus.write_lock_req[cand_idx]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_idx;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Owner-side views: request, byte strobe, data and flow control.
  always_comb begin
    owner_req_s     = 1'b0;
    owner_valid_s   = 1'b0;
    owner_data_s    = 8'h00;
    bus.write_ready = '0;
    for (int i = 0; i < NTHREADS; i++) begin
      if (owner_r == OW'(i)) begin
        owner_req_s        = bus.write_lock_req[i];
        owner_valid_s      = bus.write_data_valid[i];
        owner_data_s       = bus.write_data[8*i +: 8];
        bus.write_ready[i] = grant_active_s && (count_r <= READY_LIMIT);
      end else begin
        bus.write_ready[i] = 1'b0;
      end
    end
  end

  assign bus.write_lock_res = lock_res_r;

  // Arbiter FSM: grant, hold until the owner drops its request, one-cycle release.
  always_ff @(posedge clock) begin
    if (reset) begin
      arb_state_r <= ARB_IDLE;
      owner_r     <= '0;
      rr_ptr_r    <= '0;
      lock_res_r  <= '0;
    end else begin
      case (arb_state_r)
        ARB_IDLE: begin
          if (pick_found_s) begin
            arb_state_r <= ARB_GRANT;
            owner_r     <= pick_idx_s;
            lock_res_r  <= onehot(pick_idx_s);
          end
        end
        ARB_GRANT: begin
          if (!owner_req_s) begin
            arb_state_r <= ARB_RELEASE;
            lock_res_r  <= '0;
            rr_ptr_r    <= (owner_r == OWNER_LAST) ? '0 : owner_r + 1'b1;
          end
        end
        ARB_RELEASE: arb_state_r <= ARB_IDLE;
        default: begin
          arb_state_r <= ARB_IDLE;
          lock_res_r  <= '0;
        end
      endcase
    end
  end

  assign fifo_empty_s = (count_r == '0);
  assign fifo_full_s  = (count_r == FULL_COUNT);
  assign fifo_head_s  = mem_r[rd_ptr_r];
  assign baud_end_s   = (baud_cnt_r == BIT_LAST);
  assign pop_s        = !fifo_empty_s &&
                        ((tx_state_r == TX_IDLE) || ((tx_state_r == TX_STOP) && baud_end_s));
  // A full FIFO still accepts a byte when the transmitter frees a slot this cycle.
  assign push_req_s   = grant_active_s && owner_valid_s;
  assign push_s       = push_req_s && (!fifo_full_s || pop_s);
  assign drop_s       = push_req_s && fifo_full_s && !pop_s;

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= owner_data_s;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
      overflow <= overflow | drop_s;
    end
  end

  // 8N1 transmitter, LSB first, frames chained without gap while bytes remain.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_r <= TX_IDLE;
      baud_cnt_r <= '0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      uart_tx    <= 1'b1;
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          baud_cnt_r <= '0;
          if (pop_s) begin
            shift_r    <= fifo_head_s;
            uart_tx    <= 1'b0;
            tx_state_r <= TX_START;
          end else begin
            uart_tx <= 1'b1;
          end
        end
        TX_START: begin
          if (baud_end_s) begin
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            uart_tx    <= shift_r[0];
            tx_state_r <= TX_DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_end_s) begin
            baud_cnt_r <= '0;
            if (bit_idx_r == 3'd7) begin
              uart_tx    <= 1'b1;
              tx_state_r <= TX_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              uart_tx   <= shift_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        TX_STOP: begin
          if (baud_end_s) begin
            baud_cnt_r <= '0;
            if (pop_s) begin
              shift_r    <= fifo_head_s;
              uart_tx    <= 1'b0;
              tx_state_r <= TX_START;
            end else begin
              uart_tx    <= 1'b1;
              tx_state_r <= TX_IDLE;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        default: begin
          tx_state_r <= TX_IDLE;
          uart_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign idle = (lock_res_r == '0) && fifo_empty_s && (tx_state_r == TX_IDLE);
endmodule

// File: tb/tb_uart_write_arbiter.sv
// Scoreboard bench for uart_write_arbiter: drivers queue expected bytes,
// a serial monitor decodes uart_tx frames and checks them in order.
module tb_uart_write_arbiter;
  localparam int NT  = 2;
  localparam int FD  = 8;
  localparam int CPB = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic uart_tx;
  logic overflow;
  logic idle;

  uart_write_arbiter_if #(.NTHREADS(NT)) bus();

  uart_write_arbiter #(.NTHREADS(NT), .FIFO_DEPTH(FD), .CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .uart_tx(uart_tx), .overflow(overflow), .idle(idle)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; int gap; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int passes = 0;
  int frames = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push_exp(input logic [7:0] d, input int gap);
    exp_t e;
    e.data = d;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!(idle === 1'b1 && sb.size() == 0) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check({name, "_idle"}, int'(idle), 1);
    check({name, "_queue_empty"}, sb.size(), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    bus.write_lock_req   = '0;
    bus.write_data_valid = '0;
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Serial monitor: samples mid-bit on falling edges, compares against the scoreboard.
  initial begin : monitor
    logic [7:0] rx;
    logic       stop_bit;
    logic       aborted;
    int         start_cyc;
    int         last_start;
    exp_t       e;
    last_start = 0;
    forever begin
      @(negedge clock);
      if (reset === 1'b0 && uart_tx === 1'b0) begin
        start_cyc = cyc;
        frames++;
        aborted  = 1'b0;
        rx       = 8'h00;
        stop_bit = 1'b0;
        for (int k = 1; k <= 38; k++) begin
          @(negedge clock);
          if (reset === 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (k >= 6 && k <= 34 && ((k - 6) % 4) == 0) rx[(k - 6) / 4] = uart_tx;
          if (k == 38) stop_bit = uart_tx;
        end
        if (!aborted) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_frame: got byte 0x%0h required no frame", rx);
          end else begin
            e = sb.pop_front();
            check("frame_data", int'(rx), int'(e.data));
            check("stop_bit", int'(stop_bit), 1);
            if (e.gap >= 0) check("frame_spacing", start_cyc - last_start, e.gap);
          end
        end
        last_start = start_cyc;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stimulus
    logic [7:0] t1_bytes [5] = '{8'h05, 8'h00, 8'h00, 8'h00, 8'hA5};
    int sent;
    int drop_at;
    int guard;
    int t_fall;
    int t_rise;
    int f0;
    int n;

    bus.write_lock_req   = '0;
    bus.write_data_valid = '0;
    bus.write_data       = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_lock_res", int'(bus.write_lock_res), 0);
    check("rst_write_ready", int'(bus.write_ready), 0);
    check("rst_uart_tx", int'(uart_tx), 1);
    check("rst_overflow", int'(overflow), 0);
    check("rst_idle", int'(idle), 1);
    reset = 1'b0;
    @(negedge clock);

    // Single owner, five back-to-back frames.
    bus.write_lock_req[0] = 1'b1;
    @(negedge clock);
    check("t1_grant", int'(bus.write_lock_res), 1);
    for (int k = 0; k < 5; k++) begin
      bus.write_data[7:0]    = t1_bytes[k];
      bus.write_data_valid[0] = 1'b1;
      push_exp(t1_bytes[k], (k == 0) ? -1 : 40);
      @(negedge clock);
    end
    bus.write_data_valid = '0;
    bus.write_lock_req   = '0;
    wait_drain("t1");

    // Tie after reset, handover gap, round-robin on the next tie.
    pulse_reset();
    bus.write_lock_req = 2'b11;
    @(negedge clock);
    check("t2_tie_grant", int'(bus.write_lock_res), 1);
    bus.write_data[7:0]     = 8'h11;
    bus.write_data_valid[0] = 1'b1;
    push_exp(8'h11, -1);
    @(negedge clock);
    bus.write_data_valid  = '0;
    bus.write_lock_req[0] = 1'b0;
    t_fall = -1;
    t_rise = -1;
    for (int k = 0; k < 20; k++) begin
      if (t_fall < 0 && bus.write_lock_res[0] === 1'b0) t_fall = cyc;
      if (t_fall >= 0 && bus.write_lock_res === 2'b10) begin
        t_rise = cyc;
        break;
      end
      @(negedge clock);
    end
    check("t2_handover_gap", t_rise - t_fall, 2);
    bus.write_data[15:8]    = 8'h22;
    bus.write_data_valid[1] = 1'b1;
    push_exp(8'h22, -1);
    @(negedge clock);
    bus.write_data_valid = '0;
    bus.write_lock_req   = '0;
    repeat (4) @(negedge clock);
    bus.write_lock_req = 2'b11;
    @(negedge clock);
    check("t2_rr_tie", int'(bus.write_lock_res), 1);
    bus.write_lock_req = '0;
    @(negedge clock);
    wait_drain("t2");

    // Stream 20 bytes obeying write_ready.
    bus.write_lock_req[0] = 1'b1;
    @(negedge clock);
    sent = 0;
    drop_at = -1;
    guard = 0;
    while (sent < 20 && guard < 3000) begin
      if (bus.write_ready[0] === 1'b1) begin
        bus.write_data[7:0]     = 8'h40 + 8'(sent);
        bus.write_data_valid[0] = 1'b1;
        push_exp(8'h40 + 8'(sent), -1);
        sent++;
      end else begin
        bus.write_data_valid[0] = 1'b0;
        if (drop_at < 0) drop_at = sent;
      end
      @(negedge clock);
      guard++;
    end
    bus.write_data_valid = '0;
    bus.write_lock_req   = '0;
    check("t3_ready_drop_pushes", drop_at, 8);
    check("t3_sent", sent, 20);
    check("t3_no_overflow", int'(overflow), 0);
    wait_drain("t3");

    // Forced pushes: the tenth lands on a full FIFO and is lost.
    bus.write_lock_req[0] = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 10; k++) begin
      bus.write_data[7:0]     = 8'h80 + 8'(k);
      bus.write_data_valid[0] = 1'b1;
      if (k < 9) push_exp(8'h80 + 8'(k), -1);
      @(negedge clock);
    end
    bus.write_data_valid = '0;
    bus.write_lock_req   = '0;
    check("t4_overflow_set", int'(overflow), 1);
    wait_drain("t4");
    check("t4_overflow_sticky", int'(overflow), 1);
    pulse_reset();
    check("t4_overflow_cleared", int'(overflow), 0);

    // Non-owner strobe is ignored.
    bus.write_lock_req[0] = 1'b1;
    @(negedge clock);
    bus.write_data       = {8'hFF, 8'h5A};
    bus.write_data_valid = 2'b11;
    push_exp(8'h5A, -1);
    @(negedge clock);
    bus.write_data_valid = '0;
    bus.write_lock_req   = '0;
    wait_drain("t5");
    check("t5_no_overflow", int'(overflow), 0);

    // Reset during the data bits of 0x3C.
    bus.write_lock_req[0] = 1'b1;
    @(negedge clock);
    f0 = frames;
    bus.write_data[7:0]     = 8'h3C;
    bus.write_data_valid[0] = 1'b1;
    push_exp(8'h3C, -1);
    @(negedge clock);
    bus.write_data_valid = '0;
    n = 0;
    while (frames == f0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("t6_frame_started", int'(frames > f0), 1);
    repeat (8) @(negedge clock);
    reset = 1'b1;
    bus.write_lock_req = '0;
    sb.delete();
    @(negedge clock);
    check("t6_uart_tx_high", int'(uart_tx), 1);
    check("t6_lock_res_clear", int'(bus.write_lock_res), 0);
    check("t6_idle", int'(idle), 1);
    reset = 1'b0;
    f0 = frames;
    repeat (80) @(negedge clock);
    check("t6_no_frames_after_reset", frames, f0);
    check("t6_idle_after", int'(idle), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
